// File: rtl/sindoku_pkg.sv
// Shared types and constants for the 4x4 SINdoku core.
// Optional feature macro: SINDOKU_CONFLICT_EN (adds per-cell conflict flags).
package sindoku_pkg;

  localparam int unsigned GRID   = 4;
  localparam int unsigned CELL_W = 3;
  localparam int unsigned NCELLS = 16;

  // One-hot game states; bit order matches the q_* flag outputs.
  typedef enum logic [4:0] {
    StI         = 5'b00001,
    StSolve     = 5'b00010,
    StCheck     = 5'b00100,
    StCorrect   = 5'b01000,
    StIncorrect = 5'b10000
  } state_e;

  // Linear cell index from cursor coordinates.
  function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Bit offset of a cell inside the packed board vector.
  function automatic logic [5:0] cell_off(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] idx6;
    idx6 = {2'b00, row, col};
    return idx6 * 6'(CELL_W);
  endfunction

endpackage

// File: rtl/sindoku_checker.sv
// Combinational board validator: solved when every row, column and 2x2 box
// holds {1,2,3,4} exactly once.
// Optional feature macro: SINDOKU_CONFLICT_EN (adds conflict[15:0]).
module sindoku_checker
  import sindoku_pkg::*;
(
  input  logic [47:0] board,
  output logic        solved
`ifdef SINDOKU_CONFLICT_EN
  ,
  output logic [15:0] conflict
`endif
);

  logic [2:0] cells [NCELLS];

  // Group g: 0..3 rows, 4..7 columns, 8..11 boxes; k selects the member.
  function automatic logic [3:0] group_cell(input int unsigned g, input int unsigned k);
    int unsigned b;
    if (g < 4) begin
      return 4'(g * 4 + k);
    end else if (g < 8) begin
      return 4'(k * 4 + (g - 4));
    end
    b = g - 8;
    return 4'(((b / 2) * 2 + k / 2) * 4 + (b % 2) * 2 + (k % 2));
  endfunction

  // Unpack the board into per-cell values.
  always_comb begin
    for (int unsigned c = 0; c < NCELLS; c++) begin
      cells[c] = board[c*CELL_W +: CELL_W];
    end
  end

  // Four cells of a group cover all digits only if each is 1..4 and distinct.
  always_comb begin
    logic [3:0] seen;
    logic       bad;
    solved = 1'b1;
    for (int unsigned g = 0; g < 12; g++) begin
      seen = 4'b0000;
      bad  = 1'b0;
      for (int unsigned k = 0; k < GRID; k++) begin
        case (cells[group_cell(g, k)])
          3'd1:    seen[0] = 1'b1;
          3'd2:    seen[1] = 1'b1;
          3'd3:    seen[2] = 1'b1;
          3'd4:    seen[3] = 1'b1;
          default: bad     = 1'b1;
        endcase
      end
      if (bad || (seen != 4'b1111)) begin
        solved = 1'b0;
      end
    end
  end

`ifdef SINDOKU_CONFLICT_EN
  // A nonzero cell conflicts when a peer in its row, column or box matches it.
  always_comb begin
    conflict = '0;
    for (int unsigned i = 0; i < NCELLS; i++) begin
      for (int unsigned j = 0; j < NCELLS; j++) begin
        if ((i != j) && (cells[i] != 3'd0) && (cells[i] == cells[j]) &&
            (((i / 4) == (j / 4)) || ((i % 4) == (j % 4)) ||
             (((i / 8) == (j / 8)) && (((i % 4) / 2) == ((j % 4) / 2))))) begin
          conflict[i] = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/sindoku.sv
// SINdoku core: game FSM, cursor and board store between the button
// debouncers and the display driver.
// Optional feature macro: SINDOKU_CONFLICT_EN (exposes conflict[15:0]).
module sindoku
  import sindoku_pkg::*;
#(
  parameter logic [47:0] INIT_BOARD = 48'h204108060801,
  parameter logic [15:0] GIVEN_MASK = 16'h9669
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        L,
  input  logic        R,
  input  logic        U,
  input  logic        D,
  input  logic        C,
  input  logic        CheckSolu,
  input  logic [2:0]  userIn,
  output logic        q_I,
  output logic        q_Solve,
  output logic        q_Check,
  output logic        q_Correct,
  output logic        q_Incorrect,
  output logic [1:0]  cur_row,
  output logic [1:0]  cur_col,
  output logic [47:0] board
`ifdef SINDOKU_CONFLICT_EN
  ,
  output logic [15:0] conflict
`endif
);

  state_e      state_q, state_d;
  logic [47:0] board_q, board_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  col_q, col_d;
  logic        solved;

  sindoku_checker u_checker (
    .board  (board_q),
    .solved (solved)
`ifdef SINDOKU_CONFLICT_EN
    ,
    .conflict (conflict)
`endif
  );

  // State, board and cursor registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StI;
      board_q <= INIT_BOARD;
      row_q   <= 2'd0;
      col_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next-state logic; board and cursor only move in StI and StSolve.
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      StI: begin
        state_d = StSolve;
        board_d = INIT_BOARD;
        row_d   = 2'd0;
        col_d   = 2'd0;
      end
      StSolve: begin
        // One action per cycle: CheckSolu > C > L > R > U > D.
        if (CheckSolu) begin
          state_d = StCheck;
        end else if (C) begin
          if (!GIVEN_MASK[cell_idx(row_q, col_q)] && (userIn <= 3'd4)) begin
            board_d[cell_off(row_q, col_q) +: CELL_W] = userIn;
          end
        end else if (L) begin
          col_d = col_q - 2'd1;
        end else if (R) begin
          col_d = col_q + 2'd1;
        end else if (U) begin
          row_d = row_q - 2'd1;
        end else if (D) begin
          row_d = row_q + 2'd1;
        end
      end
      StCheck: begin
        state_d = solved ? StCorrect : StIncorrect;
      end
      StCorrect: begin
        if (C) begin
          state_d = StI;
        end
      end
      StIncorrect: begin
        if (C) begin
          state_d = StSolve;
        end
      end
      default: begin
        state_d = StI;
      end
    endcase
  end

  assign q_I         = (state_q == StI);
  assign q_Solve     = (state_q == StSolve);
  assign q_Check     = (state_q == StCheck);
  assign q_Correct   = (state_q == StCorrect);
  assign q_Incorrect = (state_q == StIncorrect);
  assign cur_row     = row_q;
  assign cur_col     = col_q;
  assign board       = board_q;

endmodule

// File: tb/tb_sindoku.sv
// Directed bench for sindoku: a reference model pushes the expected outputs
// of each driven cycle into a scoreboard queue, popped after the clock edge.
// Optional feature macro: SINDOKU_CONFLICT_EN (conflict port connected only).
module tb_sindoku;

  localparam logic [47:0] INIT_B  = 48'h204108060801;
  localparam logic [15:0] GIVEN_M = 16'h9669;
  localparam logic [47:0] SOLN_B  = 48'h29C70A4638D1;

  // {q_I, q_Solve, q_Check, q_Correct, q_Incorrect}
  localparam logic [4:0] F_I   = 5'b10000;
  localparam logic [4:0] F_SOL = 5'b01000;
  localparam logic [4:0] F_CHK = 5'b00100;
  localparam logic [4:0] F_COR = 5'b00010;
  localparam logic [4:0] F_INC = 5'b00001;

  // {CheckSolu, C, L, R, U, D}
  localparam logic [5:0] B_NONE = 6'b000000;
  localparam logic [5:0] B_CHK  = 6'b100000;
  localparam logic [5:0] B_C    = 6'b010000;
  localparam logic [5:0] B_L    = 6'b001000;
  localparam logic [5:0] B_R    = 6'b000100;
  localparam logic [5:0] B_U    = 6'b000010;
  localparam logic [5:0] B_D    = 6'b000001;

  typedef struct {
    logic [4:0]  flags;
    logic [1:0]  row;
    logic [1:0]  col;
    logic [47:0] board;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        L = 1'b0, R = 1'b0, U = 1'b0, D = 1'b0, C = 1'b0, CheckSolu = 1'b0;
  logic [2:0]  userIn = 3'd0;
  logic        q_I, q_Solve, q_Check, q_Correct, q_Incorrect;
  logic [1:0]  cur_row, cur_col;
  logic [47:0] board;
`ifdef SINDOKU_CONFLICT_EN
  logic [15:0] conflict;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic [4:0]  m_flags;
  logic [47:0] m_board;
  logic [1:0]  m_row, m_col;

  sindoku dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .L           (L),
    .R           (R),
    .U           (U),
    .D           (D),
    .C           (C),
    .CheckSolu   (CheckSolu),
    .userIn      (userIn),
    .q_I         (q_I),
    .q_Solve     (q_Solve),
    .q_Check     (q_Check),
    .q_Correct   (q_Correct),
    .q_Incorrect (q_Incorrect),
    .cur_row     (cur_row),
    .cur_col     (cur_col),
    .board       (board)
`ifdef SINDOKU_CONFLICT_EN
    ,
    .conflict    (conflict)
`endif
  );

  always #5 Clk = ~Clk;

  // Solved iff each digit 1..4 appears exactly once in every row/col/box.
  function automatic bit model_solved(input logic [47:0] b);
    int cnt [8];
    int r, c;
    bit ok;
    ok = 1'b1;
    for (int t = 0; t < 3; t++) begin
      for (int n = 0; n < 4; n++) begin
        for (int v = 0; v < 8; v++) cnt[v] = 0;
        for (int k = 0; k < 4; k++) begin
          if (t == 0) begin
            r = n; c = k;
          end else if (t == 1) begin
            r = k; c = n;
          end else begin
            r = (n / 2) * 2 + k / 2; c = (n % 2) * 2 + k % 2;
          end
          cnt[b[(r*4+c)*3 +: 3]]++;
        end
        for (int v = 1; v <= 4; v++) if (cnt[v] != 1) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  task automatic model_step(input logic rst_n, input logic [5:0] btn, input logic [2:0] uin);
    int idx;
    if (!rst_n) begin
      m_flags = F_I; m_board = INIT_B; m_row = 2'd0; m_col = 2'd0;
    end else begin
      case (m_flags)
        F_I: begin
          m_flags = F_SOL; m_board = INIT_B; m_row = 2'd0; m_col = 2'd0;
        end
        F_SOL: begin
          idx = m_row * 4 + m_col;
          if (btn[5]) m_flags = F_CHK;
          else if (btn[4]) begin
            if (!GIVEN_M[idx] && uin <= 3'd4) m_board[idx*3 +: 3] = uin;
          end
          else if (btn[3]) m_col = m_col - 2'd1;
          else if (btn[2]) m_col = m_col + 2'd1;
          else if (btn[1]) m_row = m_row - 2'd1;
          else if (btn[0]) m_row = m_row + 2'd1;
        end
        F_CHK: m_flags = model_solved(m_board) ? F_COR : F_INC;
        F_COR: if (btn[4]) m_flags = F_I;
        F_INC: if (btn[4]) m_flags = F_SOL;
        default: m_flags = F_I;
      endcase
    end
  endtask

  task automatic check_out();
    exp_t e;
    logic [4:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard: observed empty queue, expected an entry");
      return;
    end
    e = sb.pop_front();
    obs = {q_I, q_Solve, q_Check, q_Correct, q_Incorrect};
    assert (obs === e.flags) else begin
      errors++;
      $error("FAIL flags: observed %b expected %b", obs, e.flags);
    end
    checks++;
    assert (cur_row === e.row) else begin
      errors++;
      $error("FAIL cur_row: observed %0d expected %0d", cur_row, e.row);
    end
    checks++;
    assert (cur_col === e.col) else begin
      errors++;
      $error("FAIL cur_col: observed %0d expected %0d", cur_col, e.col);
    end
    checks++;
    assert (board === e.board) else begin
      errors++;
      $error("FAIL board: observed %h expected %h", board, e.board);
    end
  endtask

  task automatic check_board(input string tag, input logic [47:0] expv);
    checks++;
    assert (board === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, board, expv);
    end
  endtask

  task automatic cycle(input logic rst_n, input logic [5:0] btn, input logic [2:0] uin);
    exp_t e;
    @(negedge Clk);
    Reset = rst_n;
    {CheckSolu, C, L, R, U, D} = btn;
    userIn = uin;
    model_step(rst_n, btn, uin);
    e.flags = m_flags; e.row = m_row; e.col = m_col; e.board = m_board;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    check_out();
    Reset = 1'b1;
    {CheckSolu, C, L, R, U, D} = B_NONE;
  endtask

  task automatic write_cell(input logic [1:0] r, input logic [1:0] c, input logic [2:0] v);
    while (m_col != c) cycle(1'b1, B_R, 3'd0);
    while (m_row != r) cycle(1'b1, B_D, 3'd0);
    cycle(1'b1, B_C, v);
  endtask

  task automatic fill_solution();
    write_cell(2'd0, 2'd1, 3'd2);
    write_cell(2'd0, 2'd2, 3'd3);
    write_cell(2'd1, 2'd0, 3'd3);
    write_cell(2'd1, 2'd3, 3'd2);
    write_cell(2'd2, 2'd0, 3'd2);
    write_cell(2'd2, 2'd3, 3'd3);
    write_cell(2'd3, 2'd1, 3'd3);
    write_cell(2'd3, 2'd2, 3'd2);
  endtask

  initial begin
    // Reset, then one cycle of q_I, then q_Solve.
    cycle(1'b0, B_NONE, 3'd0);
    check_board("reset_board", INIT_B);
    cycle(1'b1, B_NONE, 3'd0);
    cycle(1'b1, B_NONE, 3'd0);

    // Cursor wrap around all four edges.
    cycle(1'b1, B_L, 3'd0);
    cycle(1'b1, B_U, 3'd0);
    cycle(1'b1, B_R, 3'd0);
    cycle(1'b1, B_D, 3'd0);

    // Editing: given cell, valid digit, invalid digit, clear.
    cycle(1'b1, B_C, 3'd2);
    cycle(1'b1, B_R, 3'd0);
    cycle(1'b1, B_C, 3'd2);
    cycle(1'b1, B_C, 3'd6);
    cycle(1'b1, B_C, 3'd0);
    cycle(1'b1, B_C, 3'd3);

    // Incomplete board: check fails, inputs ignored, C resumes solving.
    cycle(1'b1, B_CHK, 3'd0);
    cycle(1'b1, B_L | B_C, 3'd1);
    cycle(1'b1, B_NONE, 3'd0);
    cycle(1'b1, B_L | B_CHK, 3'd0);
    cycle(1'b1, B_C, 3'd0);

    // Full solution: correct two cycles after CheckSolu, C starts a new game.
    fill_solution();
    check_board("solution_board", SOLN_B);
    cycle(1'b1, B_CHK, 3'd0);
    cycle(1'b1, B_NONE, 3'd0);
    cycle(1'b1, B_R | B_CHK, 3'd0);
    cycle(1'b1, B_C, 3'd0);
    cycle(1'b1, B_NONE, 3'd0);
    check_board("new_game_board", INIT_B);

    // Simultaneous CheckSolu + C + L: only the check happens.
    cycle(1'b1, B_R, 3'd0);
    cycle(1'b1, B_CHK | B_C | B_L, 3'd3);
    cycle(1'b1, B_NONE, 3'd0);
    cycle(1'b1, B_C, 3'd0);

    // Reach q_Correct again, then reset there.
    fill_solution();
    cycle(1'b1, B_CHK, 3'd0);
    cycle(1'b1, B_NONE, 3'd0);
    cycle(1'b0, B_C | B_L, 3'd1);
    cycle(1'b1, B_NONE, 3'd0);

    // Reset wins over a move pulse in q_Solve.
    cycle(1'b1, B_D, 3'd0);
    cycle(1'b0, B_D, 3'd0);
    cycle(1'b1, B_NONE, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
